// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only instruction/fetch cache controller.
// 16 lines x 32 bytes; tag RAM and valid bits held internally, the line
// data lives in an external array addressed by data_req_index_o.
// Optional macro CACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
module cache_ctrl #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_ready_o,
    output logic [63:0]       cpu_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [255:0]      mem_rdata_i,
    output logic [3:0]        data_req_index_o,
    output logic              data_req_we_o,
    output logic [255:0]      data_write_o,
    input  logic [255:0]      data_read_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned TAG_W = ADDR_W - 9;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TAG_W-1:0]    r_tag [16];
    logic [15:0]         r_valid;
    logic [255:0]        r_line;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic [3:0]          w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_off;
    logic                w_hit;
    logic                w_unused;

    assign w_idx    = cpu_addr_i[8:5];
    assign w_tag    = cpu_addr_i[ADDR_W-1:9];
    assign w_off    = cpu_addr_i[4:3];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused = ^cpu_addr_i[2:0];

    assign data_req_index_o = w_idx;
    assign data_write_o     = r_line;
    assign mem_addr_o       = r_mem_addr;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; outputs are held quiet while reset is asserted
    always_comb begin
        w_next        = r_state;
        cpu_ready_o   = 1'b0;
        cpu_data_o    = data_read_i[{w_off, 6'b0} +: 64];
        mem_req_o     = 1'b0;
        data_req_we_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cpu_req_i) begin
                    if (w_hit) begin
                        cpu_ready_o = !rst_i;
                    end else begin
                        w_next = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req_o = !rst_i;
                if (mem_ack_i) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                data_req_we_o = !rst_i;
                cpu_ready_o   = cpu_req_i && !rst_i;
                cpu_data_o    = r_line[{w_off, 6'b0} +: 64];
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Refill address capture, line buffer and tag/valid update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= '0;
            r_line     <= '0;
            r_mem_addr <= '0;
        end else begin
            if (r_state == IDLE && cpu_req_i && !w_hit) begin
                r_mem_addr <= {w_tag, w_idx, 5'b0};
            end
            if (r_state == REFILL && mem_ack_i) begin
                r_line <= mem_rdata_i;
            end
            if (r_state == FILL) begin
                r_tag[w_idx]   <= w_tag;
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    // Hit / miss statistics, wrapping at 2^32
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == IDLE && cpu_req_i) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized self-checking bench for cache_ctrl.
// A behavioural cache model (valid/tag/line arrays) predicts hit or miss and
// the returned doubleword; the bench also plays memory and the data array.
module tb_cache_ctrl;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           cpu_req_i;
    logic [63:0]    cpu_addr_i;
    logic           cpu_ready_o;
    logic [63:0]    cpu_data_o;
    logic           mem_req_o;
    logic [63:0]    mem_addr_o;
    logic           mem_ack_i;
    logic [255:0]   mem_rdata_i;
    logic [3:0]     data_req_index_o;
    logic           data_req_we_o;
    logic [255:0]   data_write_o;
    logic [255:0]   data_read_i;
`ifdef CACHE_STATS_EN
    logic [31:0]    hit_cnt_o;
    logic [31:0]    miss_cnt_o;
`endif

    cache_ctrl #(.ADDR_W(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cpu_req_i        (cpu_req_i),
        .cpu_addr_i       (cpu_addr_i),
        .cpu_ready_o      (cpu_ready_o),
        .cpu_data_o       (cpu_data_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .data_req_index_o (data_req_index_o),
        .data_req_we_o    (data_req_we_o),
        .data_write_o     (data_write_o),
        .data_read_i      (data_read_i)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // External data array the controller reads combinationally
    logic [255:0] darr [16];
    assign data_read_i = darr[data_req_index_o];
    always @(posedge clk_i) begin
        if (data_req_we_o) darr[data_req_index_o] <= data_write_o;
    end

    // Reference model state
    logic          m_valid [16];
    logic [54:0]   m_tag   [16];
    logic [255:0]  m_line  [16];
    int unsigned   m_hits;
    int unsigned   m_misses;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One complete CPU fetch; waits = memory-wait cycles before the ack cycle
    task automatic access(input logic [63:0] addr, input int unsigned waits);
        logic [3:0]   idx;
        logic [54:0]  tg;
        logic [1:0]   dw;
        logic         hit;
        logic [255:0] line;
        idx = addr[8:5];
        tg  = addr[63:9];
        dw  = addr[4:3];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = addr;
        @(negedge clk_i);
        check("index", 256'(data_req_index_o), 256'(idx));
        check("we_idle", 256'(data_req_we_o), 256'(0));
        if (hit) begin
            check("hit_ready", 256'(cpu_ready_o), 256'(1));
            check("hit_data", 256'(cpu_data_o), 256'(m_line[idx][64*dw +: 64]));
            check("hit_memreq", 256'(mem_req_o), 256'(0));
            m_hits++;
        end else begin
            check("miss_ready", 256'(cpu_ready_o), 256'(0));
            m_misses++;
            line = rand_line();
            for (int unsigned w = 0; w <= waits; w++) begin
                @(posedge clk_i); #1;
                if (w == waits) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = line;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = rand_line();
                end
                @(negedge clk_i);
                check("refill_memreq", 256'(mem_req_o), 256'(1));
                check("refill_addr", 256'(mem_addr_o), 256'({tg, idx, 5'b0}));
                check("refill_ready", 256'(cpu_ready_o), 256'(0));
                check("refill_we", 256'(data_req_we_o), 256'(0));
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            @(negedge clk_i);
            check("fill_we", 256'(data_req_we_o), 256'(1));
            check("fill_line", data_write_o, line);
            check("fill_index", 256'(data_req_index_o), 256'(idx));
            check("fill_ready", 256'(cpu_ready_o), 256'(1));
            check("fill_data", 256'(cpu_data_o), 256'(line[64*dw +: 64]));
            check("fill_memreq", 256'(mem_req_o), 256'(0));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_line[idx]  = line;
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        @(negedge clk_i);
        check({tag, "_hits"}, 256'(hit_cnt_o), 256'(m_hits));
        check({tag, "_misses"}, 256'(miss_cnt_o), 256'(m_misses));
`else
        check({tag, "_idle_memreq"}, 256'(mem_req_o), 256'(0));
`endif
    endtask

    initial begin
        logic [63:0] a;
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_addr_i  = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_memreq", 256'(mem_req_o), 256'(0));
        check("rst_we", 256'(data_req_we_o), 256'(0));
        check("rst_ready", 256'(cpu_ready_o), 256'(0));
        check("rst_addr", 256'(mem_addr_o), 256'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Directed: cold miss, hit on the same line, conflict replacement
        access(64'h40, 3);
        access(64'h48, 0);
        access(64'h240, 1);
        access(64'h40, 2);
        check_stats("directed");
`ifdef CACHE_STATS_EN
        check("directed_hit1", 256'(hit_cnt_o), 256'(1));
        check("directed_miss3", 256'(miss_cnt_o), 256'(3));
`endif

        // Stray ack while idle must be ignored
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = rand_line();
        @(negedge clk_i);
        check("stray_we", 256'(data_req_we_o), 256'(0));
        check("stray_memreq", 256'(mem_req_o), 256'(0));
        check("stray_ready", 256'(cpu_ready_o), 256'(0));
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("stray_we2", 256'(data_req_we_o), 256'(0));
        check("stray_memreq2", 256'(mem_req_o), 256'(0));
        access(64'h50, 0);

        // Randomized fetches over a small tag pool so hits and conflicts occur
        for (int n = 0; n < 150; n++) begin
            a = {53'($urandom_range(0, 2)), 2'b0, 4'($urandom), 5'($urandom)};
            access(a, $urandom_range(0, 3));
        end
        check_stats("random");

        // Reset while refilling: refill abandoned, late ack ignored
        a = 64'h0000_1234_5660;
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        @(negedge clk_i);
        check("rr_miss", 256'(cpu_ready_o), 256'(0));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rr_memreq_before", 256'(mem_req_o), 256'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_rdata_i = rand_line();
        model_reset();
        @(negedge clk_i);
        check("rr_memreq_after", 256'(mem_req_o), 256'(0));
        check("rr_we_ack", 256'(data_req_we_o), 256'(0));
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("rr_we_next", 256'(data_req_we_o), 256'(0));
        check("rr_ready", 256'(cpu_ready_o), 256'(0));
        access(a, 1);
        access(64'h40, 0);
        for (int n = 0; n < 30; n++) begin
            a = {53'($urandom_range(0, 1)), 2'b0, 4'($urandom), 5'($urandom)};
            access(a, $urandom_range(0, 2));
        end
        check_stats("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter: ADDR_W, 64, CPU byte-address width; tag width = ADDR_W-9.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 cpu_req_i  in  1  fetch request; held with address stable until cpu_ready_o.
REQ-005 cpu_addr_i  in  ADDR_W  byte address; [4:0] offset, [8:5] index, [ADDR_W-1:9] tag.
REQ-006 cpu_ready_o  out  1  request complete this cycle; cpu_data_o valid.
REQ-007 cpu_data_o  out  64  doubleword at cpu_addr_i[4:3] of addressed line.
REQ-008 mem_req_o  out  1  line-refill request to memory.
REQ-009 mem_addr_o  out  ADDR_W  line-aligned refill address ([4:0]=0).
REQ-010 mem_ack_i  in  1  one-cycle pulse; mem_rdata_i valid.
REQ-011 mem_rdata_i  in  256  refill line, byte 0 at bits [7:0].
REQ-012 data_req_index_o  out  4  line index to data array.
REQ-013 data_req_we_o  out  1  data-array write enable.
REQ-014 data_write_o  out  256  line written to data array.
REQ-015 data_read_i  in  256  combinational data-array read of data_req_index_o.

Function
REQ-016 Direct-mapped, 16 lines x 32 bytes; internal tag RAM (16 x ADDR_W-9) and 16 valid bits, read-only (no CPU writes).
REQ-017 data_req_index_o = cpu_addr_i[8:5] at all times.
REQ-018 States: IDLE, REFILL, FILL; state register resets to IDLE.
REQ-019 IDLE, cpu_req_i=1, valid[idx]=1 and tag match: cpu_ready_o=1 same cycle (zero-cycle hit), cpu_data_o = data_read_i[64*addr[4:3] +: 64]; stay IDLE.
REQ-020 IDLE, cpu_req_i=1, miss: cpu_ready_o=0; next state REFILL; mem_addr_o registered as {tag,idx,5'b0}.
REQ-021 REFILL: mem_req_o=1 held until and including the mem_ack_i cycle; on ack, mem_rdata_i latched into line buffer, go FILL.
REQ-022 FILL (one cycle): data_req_we_o=1, data_write_o=line buffer, tag[idx]<=tag, valid[idx]<=1, cpu_ready_o=1, cpu_data_o taken from line buffer; next IDLE.
REQ-023 Miss latency: ready asserted exactly 2 cycles after the mem_ack_i cycle's state entry, i.e. request cycle + 1 (REFILL entry) + N memory-wait cycles + 1 (FILL).
REQ-024 mem_ack_i outside REFILL ignored; data_req_we_o=0 outside FILL.
REQ-025 cpu_ready_o=0 whenever cpu_req_i=0; cpu_data_o don't-care when cpu_ready_o=0.
REQ-026 Refill replaces resident line unconditionally (no dirty state).

Reset
REQ-027 On rst_i: state<=IDLE, all valid<=0, line buffer and mem_addr_o<=0; outputs during/after reset: mem_req_o=0, data_req_we_o=0, cpu_ready_o=0.
REQ-028 Reset mid-REFILL abandons the refill; mem_req_o deasserts the cycle after reset sampled; any later ack ignored.
REQ-029 Reset during FILL: write suppressed, valid bit stays 0.

Configuration
REQ-030 Macro CACHE_STATS_EN: when defined, outputs hit_cnt_o[31:0] and miss_cnt_o[31:0] exist; hit_cnt_o +1 per REQ-019 hit, miss_cnt_o +1 per IDLE->REFILL transition; both wrap at 2^32, cleared by rst_i.
REQ-031 Without CACHE_STATS_EN: those ports and counters absent; all other behaviour identical.

Verification
REQ-032 After reset, req addr 0x0000_0040 -> miss; mem_req_o=1, mem_addr_o=0x40; ack after 3 cycles with line pattern -> FILL writes index 2, ready with correct doubleword.
REQ-033 Repeat req 0x48 after REQ-032 -> ready same cycle, data = line bytes 8..15, no mem_req_o.
REQ-034 Req 0x240 (same index 2, new tag) -> miss, refill, line replaced; then 0x40 misses again.
REQ-035 rst_i asserted during REFILL, then mem_ack_i pulse -> no array write, valid[idx]=0, next access misses.
REQ-036 CACHE_STATS_EN defined, sequence of REQ-032..034 -> hit_cnt_o=1, miss_cnt_o=3.
REQ-037 Stray mem_ack_i in IDLE with cpu_req_i=0 -> no state change, data_req_we_o stays 0.
